// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped, read-only instruction cache with fetch-stall control.
// 32 lines of 8 words each. On a miss the PC is held via stall_o while the
// line is fetched from backing memory over an enable/ack handshake, and then
// written into the line. Hits are served combinationally in the same cycle.
module icache_fetch_ctrl #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 22  // must equal 32 - 5 - IDX_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [31:0]  addr_i,
  input  logic         invalidate_i,
  output logic [31:0]  inst_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic [31:0]  mem_addr_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int LINES  = 1 << IDX_W;
  localparam int LINE_W = 32 - 5;  // bits of a line-aligned address above the byte offset

  typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;

  // Controller state
  state_t              r_state;
  logic [LINE_W-1:0]   r_line_addr;   // addr_i[31:5] captured at the miss
  logic                r_mem_enable;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  // Line storage: valid bits are reset, tag/data arrays are not
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag_mem  [LINES];
  logic [255:0]        r_data_mem [LINES];

  // Address split of the current fetch
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [2:0]          w_word;
  assign w_tag  = addr_i[31 -: TAG_W];
  assign w_idx  = addr_i[5 +: IDX_W];
  assign w_word = addr_i[4:2];

  // Byte offset within a word plays no role in an instruction fetch
  logic w_unused;
  assign w_unused = ^addr_i[1:0];

  // Index/tag of the line being refilled, taken from the captured address so
  // they stay correct even though addr_i is only guaranteed stable, not latched
  logic [IDX_W-1:0]    w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  assign w_fill_idx = r_line_addr[0 +: IDX_W];
  assign w_fill_tag = r_line_addr[LINE_W-1 -: TAG_W];

  // Lookup
  logic                w_in_idle;
  logic                w_hit;
  logic                w_ack_take;
  logic [255:0]        w_line;
  logic [31:0]         w_word_data;
  assign w_in_idle   = (r_state == IDLE);
  assign w_hit       = w_in_idle & req_i & r_valid[w_idx] &
                       (r_tag_mem[w_idx] == w_tag) & ~invalidate_i;
  assign w_ack_take  = (r_state == MISS) & mem_ack_i;
  assign w_line      = r_data_mem[w_idx];
  assign w_word_data = w_line[{w_word, 5'b00000} +: 32];

  // Per-line valid-set strobes on an accepted refill
  logic [LINES-1:0]    w_fill_sel;
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_fill_sel
      assign w_fill_sel[gi] = w_ack_take & (w_fill_idx == IDX_W'(gi));
    end
  endgenerate

  // Outputs: stall is combinational so the PC holds in the very cycle of a miss
  assign stall_o      = ~w_in_idle | (req_i & ~w_hit);
  assign inst_o       = w_hit ? w_word_data : 32'h0;
  assign mem_enable_o = r_mem_enable;
  assign mem_addr_o   = r_mem_enable ? {r_line_addr, 5'b00000} : 32'h0;
  assign hit_cnt_o    = r_hit_cnt;
  assign miss_cnt_o   = r_miss_cnt;

  // Fetch FSM: tracks the miss/refill sequence, owns the memory request and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_mem_enable <= 1'b0;
      r_line_addr  <= '0;
      r_hit_cnt    <= 32'h0;
      r_miss_cnt   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'h1;
          end else if (req_i) begin
            r_miss_cnt   <= r_miss_cnt + 32'h1;
            r_line_addr  <= addr_i[31:5];
            r_mem_enable <= 1'b1;
            r_state      <= MISS;
          end
        end
        MISS: begin
          // Request and address stay put until memory answers
          if (mem_ack_i) begin
            r_mem_enable <= 1'b0;
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          // Line is now written; the hit is served from IDLE next cycle
          r_state <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_mem_enable <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits: invalidate only takes effect in IDLE; a refill in flight still lands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (w_in_idle && invalidate_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_fill_sel;
    end
  end

  // Tag/data arrays: written only by an accepted refill, never reset
  always_ff @(posedge clk_i) begin
    if (w_ack_take) begin
      r_tag_mem[w_fill_idx]  <= w_fill_tag;
      r_data_mem[w_fill_idx] <= mem_data_i;
    end
  end

endmodule
